// File: rtl/leaf_sweep_sequencer_if.sv
// leaf_sweep_sequencer_if: sweep control, table config and result handshake bundle
interface leaf_sweep_sequencer_if #(parameter int W = 32);
   logic         start;
   logic [W-1:0] base;
   logic         busy;
   logic         cfg_we;
   logic         cfg_sel;
   logic [3:0]   cfg_addr;
   logic [W-1:0] cfg_data;
   logic         cfg_err;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   out_leaf;
   logic [W-1:0] out_value;
   logic [4:0]   out_h;
   logic [W-1:0] out_p1;
   logic         done;
   modport master (output start, base, cfg_we, cfg_sel, cfg_addr, cfg_data, out_ready,
                   input busy, cfg_err, out_valid, out_leaf, out_value, out_h, out_p1, done);
   modport slave (input start, base, cfg_we, cfg_sel, cfg_addr, cfg_data, out_ready,
                  output busy, cfg_err, out_valid, out_leaf, out_value, out_h, out_p1, done);
endinterface

// File: rtl/leaf_sweep_sequencer.sv
// leaf_sweep_sequencer: walks 16 leaves of a 4-level tree, emitting one masked index transform per leaf
module leaf_sweep_sequencer #(
   parameter int W      = 32,
   parameter int DEF_H  = 24,
   parameter int DEF_P1 = 0
) (
   input logic clk,
   input logic rst,
   leaf_sweep_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, OUT, DONE} state_t;
   state_t       state, state_n;
   logic [W-1:0] base_r, acc, src, mul, mask;
   logic [3:0]   leaf;
   logic [1:0]   stage;
   logic         cfg_err;
   logic [4:0]   h_tab [16];
   logic [W-1:0] p1_tab [16];
   logic         out_valid;

   always_ff @(posedge clk) state <= rst ? IDLE : state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = bus.start ? CALC : IDLE;
         CALC: state_n = (stage == 2'd3) ? OUT : CALC;
         OUT:  state_n = !bus.out_ready ? OUT : (leaf == 4'd15) ? DONE : CALC;
         DONE: state_n = IDLE;
      endcase
   end

   // stage k multiplies by {4,4,3,2}; stage 0 restarts from the captured base
   assign src  = (stage == 2'd0) ? base_r : acc;
   assign mul  = (stage == 2'd3) ? src << 1 : (stage == 2'd2) ? src + (src << 1) : src << 2;
   assign mask = {W{1'b1}} >> (W - 1 - int'(h_tab[leaf]));

   always_ff @(posedge clk) begin
      if (rst) begin
         base_r  <= '0;
         acc     <= '0;
         leaf    <= '0;
         stage   <= '0;
         cfg_err <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            h_tab[i]  <= 5'(DEF_H);
            p1_tab[i] <= W'(DEF_P1);
         end
      end else begin
         cfg_err <= bus.cfg_we && state != IDLE;
         if (state == IDLE && bus.cfg_we && !bus.cfg_sel) h_tab[bus.cfg_addr] <= bus.cfg_data[4:0];
         if (state == IDLE && bus.cfg_we && bus.cfg_sel) p1_tab[bus.cfg_addr] <= bus.cfg_data;
         if (state == IDLE && bus.start) begin
            base_r <= bus.base;
            leaf   <= '0;
            stage  <= '0;
         end
         if (state == CALC) begin
            acc   <= mul + {{(W-1){1'b0}}, leaf[~stage]};
            stage <= stage + 2'd1;
         end
         if (state == OUT && bus.out_ready && leaf != 4'd15) leaf <= leaf + 4'd1;
      end
   end

   assign out_valid     = state == OUT;
   assign bus.out_valid = out_valid;
   assign bus.busy      = state != IDLE;
   assign bus.done      = state == DONE;
   assign bus.cfg_err   = cfg_err;
   assign bus.out_leaf  = out_valid ? leaf : '0;
   assign bus.out_value = out_valid ? acc & mask : '0;
   assign bus.out_h     = out_valid ? h_tab[leaf] : '0;
   assign bus.out_p1    = out_valid ? p1_tab[leaf] : '0;
endmodule

// File: tb/tb_leaf_sweep_sequencer.sv
// tb_leaf_sweep_sequencer: randomized sweeps checked against an arithmetic leaf-path model
module tb_leaf_sweep_sequencer;
   localparam int W = 32;
   logic clk = 0;
   logic rst = 1;
   int n_chk = 0;
   int n_err = 0;
   logic [4:0]   mh [16];
   logic [W-1:0] mp [16];
   logic [W-1:0] res [16];

   always #5 clk = ~clk;

   leaf_sweep_sequencer_if #(.W(W)) bus ();
   leaf_sweep_sequencer #(.W(W), .DEF_H(24), .DEF_P1(0)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] model(logic [W-1:0] b, int l, logic [4:0] h);
      int m [4] = '{4, 4, 3, 2};
      logic [W-1:0] a = b;
      for (int k = 0; k < 4; k++) a = a * W'(m[k]) + W'((l >> (3 - k)) & 1);
      return (h == 5'd31) ? a : a & ((32'd1 << (h + 5'd1)) - 32'd1);
   endfunction

   task automatic model_reset;
      for (int i = 0; i < 16; i++) begin
         mh[i] = 5'd24;
         mp[i] = '0;
      end
   endtask

   task automatic do_reset;
      rst = 1;
      step;
      step;
      rst = 0;
      model_reset;
   endtask

   task automatic set_cfg(logic sel, logic [3:0] a, logic [W-1:0] d);
      bus.cfg_we = 1;
      bus.cfg_sel = sel;
      bus.cfg_addr = a;
      bus.cfg_data = d;
      if (sel) mp[a] = d;
      else mh[a] = d[4:0];
   endtask

   task automatic cfg_wr(logic sel, logic [3:0] a, logic [W-1:0] d);
      set_cfg(sel, a, d);
      step;
      bus.cfg_we = 0;
      chk("cfg_err_idle", bus.cfg_err, 0);
   endtask

   task automatic sweep(logic [W-1:0] b, int hold_leaf, int hold_n, int inj_leaf, int rst_leaf, bit rnd);
      int cnt;
      int n;
      logic [W-1:0] ev;
      bus.base = b;
      bus.start = 1;
      if (rnd && $urandom_range(1) == 1) set_cfg(1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
      step;
      bus.start = 0;
      bus.cfg_we = 0;
      chk("cfg_err_start", bus.cfg_err, 0);
      for (int l = 0; l < 16; l++) begin
         cnt = 1;
         if (l == rst_leaf) begin
            rst = 1;
            step;
            rst = 0;
            model_reset;
            chk("rst_busy", bus.busy, 0);
            chk("rst_valid", bus.out_valid, 0);
            return;
         end
         if (l == inj_leaf) begin
            bus.cfg_we = 1;
            bus.cfg_sel = 0;
            bus.cfg_addr = 4'd1;
            bus.cfg_data = 32'd5;
            bus.start = 1;
            step;
            cnt++;
            bus.cfg_we = 0;
            bus.start = 0;
            chk("cfg_err_busy", bus.cfg_err, 1);
         end
         while (!bus.out_valid && cnt < 12) begin
            step;
            cnt++;
         end
         chk("latency", cnt, 5);
         ev = model(b, l, mh[l]);
         chk("leaf", bus.out_leaf, l);
         chk("value", bus.out_value, ev);
         chk("h", bus.out_h, mh[l]);
         chk("p1", bus.out_p1, mp[l]);
         res[l] = bus.out_value;
         n = (l == hold_leaf) ? hold_n : rnd ? $urandom_range(2) : 0;
         if (n > 0) begin
            bus.out_ready = 0;
            repeat (n) begin
               step;
               chk("hold_valid", bus.out_valid, 1);
               chk("hold_leaf", bus.out_leaf, l);
               chk("hold_value", bus.out_value, ev);
               chk("hold_p1", bus.out_p1, mp[l]);
            end
            bus.out_ready = 1;
         end
         step;
         chk("done", bus.done, l == 15);
      end
      chk("busy_in_done", bus.busy, 1);
      step;
      chk("done_once", bus.done, 0);
      chk("idle", bus.busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      bus.start = 0;
      bus.base = '0;
      bus.cfg_we = 0;
      bus.cfg_sel = 0;
      bus.cfg_addr = '0;
      bus.cfg_data = '0;
      bus.out_ready = 1;
      do_reset;
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_cfg_err", bus.cfg_err, 0);
      chk("rst_leaf", bus.out_leaf, 0);
      chk("rst_value", bus.out_value, 0);
      chk("rst_h", bus.out_h, 0);
      chk("rst_p1", bus.out_p1, 0);

      for (int i = 0; i < 16; i++) cfg_wr(0, 4'(i), ($urandom & ~32'h1f) | 32'd31);
      sweep(32'd0, -1, 0, -1, -1, 0);
      chk("base0_leaf0", res[0], 32'd0);
      chk("base0_leaf5", res[5], 32'd7);
      chk("base0_leaf15", res[15], 32'd33);

      do_reset;
      sweep(32'd1, -1, 0, -1, -1, 0);
      chk("def_leaf0", res[0], 32'd96);

      cfg_wr(0, 4'd0, 32'd3);
      cfg_wr(0, 4'd15, 32'd4);
      cfg_wr(1, 4'd15, 32'd16);
      sweep(32'd1, 2, 3, -1, -1, 0);
      chk("h3_leaf0", res[0], 32'd0);
      chk("h4_leaf15", res[15], 32'd1);

      sweep($urandom, -1, 0, 4, -1, 0);
      repeat (8) begin
         step;
         chk("no_restart", bus.busy, 0);
      end

      sweep($urandom, -1, 0, -1, 7, 0);
      sweep($urandom, -1, 0, -1, -1, 0);

      repeat (4) begin
         repeat (3) cfg_wr(1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
         sweep($urandom, -1, 0, -1, -1, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/leaf_sweep_sequencer.md
Name: leaf_sweep_sequencer

Overview:
- Sequences a 16-leaf, 4-level binary instance tree (levels 5→2, leaf at level 1) and produces one result per leaf, in leaf order 0..15.
- Per-leaf value is the composite index transform of a base value along the leaf's path, truncated to that leaf's configured width.
- Per-leaf width (h) and tag (p1) are held in a programmable table, the run-time equivalent of hierarchical parameter overrides.
- Sits between a test/stimulus master and a single shared report sink; only one leaf result is in flight at a time.

Parameters:
- W, 32, datapath and base width; all arithmetic is modulo 2^W.
- DEF_H, 24, reset value of every h table entry (leaf MSB index; effective width h+1).
- DEF_P1, 0, reset value of every p1 table entry.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- base  in  W  base value; captured on the accepted start.
- busy  out  1  high in every state except IDLE.
- cfg_we  in  1  table write strobe.
- cfg_sel  in  1  0 = h table, 1 = p1 table.
- cfg_addr  in  4  leaf index.
- cfg_data  in  W  write data; h uses bits [4:0].
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts the result.
- out_leaf  out  4  leaf index of the result.
- out_value  out  W  masked leaf value.
- out_h  out  5  h of the leaf.
- out_p1  out  W  p1 tag of the leaf.
- done  out  1  one-cycle pulse after leaf 15 is accepted.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy, out_valid, done and cfg_err = 0; out_leaf, out_value, out_h and out_p1 = 0.
  - All h entries = DEF_H; all p1 entries = DEF_P1.
  - A reset mid-sweep aborts the sweep with no further output.
- States are IDLE → CALC → OUT → (CALC | DONE) → IDLE.
- IDLE:
  - start = 1 captures base, sets leaf = 0, stage = 0 and moves to CALC.
  - A cfg_we in the same cycle as start is performed before the sweep, so it is visible to leaf 0.
- CALC: exactly 4 cycles per leaf, one level per cycle, stage k = 0..3.
  - Multipliers are M = {4, 4, 3, 2} for k = 0..3.
  - Update: acc ← acc*M[k] + leaf[3-k]. The leaf MSB selects the top level (x1 = 0, x2 = 1).
  - acc is loaded with the captured base at the start of each leaf.
  - Intermediate results wrap modulo 2^W.
- OUT:
  - out_value = acc & ((2^(h+1)) - 1); h = 31 passes all 32 bits.
  - out_h and out_p1 come from the table entry for the leaf.
  - out_valid asserts on the 5th cycle after start is accepted (4 calc cycles plus 1).
  - All out_* stay stable while out_valid = 1 and out_ready = 0.
  - The handshake completes in a cycle with out_valid & out_ready. Next cycle: leaf 15 → DONE, otherwise leaf+1 → CALC.
  - out_valid drops in CALC; there is no combinational ready→valid path.
- DONE: done = 1 for one cycle, then IDLE.
- Steady state: 5 cycles per leaf with out_ready held high; 80 cycles for a full sweep.
- start while busy is ignored; it is not queued.
- cfg_we while busy:
  - The write is dropped and the table is unchanged.
  - cfg_err pulses the next cycle.
- cfg_we in IDLE: the write takes effect the next cycle; no cfg_err.
- h table entries are 5 bits; cfg_data bits [W-1:5] are ignored for h writes.

Test Plan:
- Reset, all h = 31 via cfg, base = 0, out_ready = 1 → 16 results, leaf 0..15.
  - Leaf 0 value 0; leaf 5 value 7; leaf 15 value 33.
  - out_valid first rises 5 cycles after start; done pulses once.
- Defaults after reset, base = 1, no cfg writes → leaf 0 value 96, out_h = 24, out_p1 = 0.
- Write h[0] = 3, h[15] = 4, p1[15] = 16; base = 1 →
  - leaf 0 value 0 (96 & 15);
  - leaf 15 value 1 (129 & 31) with out_p1 = 16.
- Hold out_ready = 0 for 3 cycles on leaf 2 → out_* unchanged over those cycles; leaf 3 valid exactly 5 cycles after the accepting cycle.
- cfg_we to h[1] and a second start during a sweep → cfg_err pulse; the table and sweep are unaffected; no second sweep.
- Assert rst during CALC of leaf 7 → out_valid = 0 and busy = 0 next cycle; the h table is back to DEF_H; a new start restarts at leaf 0.
